mc_sequencer: RTL

Multi-cycle instruction sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a single shared, variable-latency memory port. It gates the write enables produced by the combinational decoder so that the PC, IR, register file and RAM update only in the correct phase. It also counts retired instructions and traps on illegal opcodes or memory timeouts.

---
 rtl/mc_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle RV32I instruction sequencer over one shared memory port
module mc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we_en,
  output logic        instr_done,
  output logic [2:0]  state,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      cur, nxt;
  logic [1:0]  cause_nxt;
  logic [15:0] wait_cnt;
  logic        wait_inc;
  logic        legal, is_load, is_store, is_branch, timed_out;
  state_t      end_state;

  assign state     = cur;
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign timed_out = (wait_cnt == WAIT_LAST);
  assign end_state = run ? S_FETCH : S_IDLE;

  always_comb begin
    case (opcode)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt          = cur;
    cause_nxt    = trap_cause;
    wait_inc     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we_en     = 1'b0;
    instr_done   = 1'b0;
    case (cur)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (timed_out) begin
          nxt       = S_TRAP;
          cause_nxt = 2'd2;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          nxt = S_EXEC;
        end else begin
          nxt       = S_TRAP;
          cause_nxt = 2'd1;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          nxt = S_MEM;
        end else if (is_branch) begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
          nxt        = end_state;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            nxt        = end_state;
          end else begin
            nxt = S_WB;
          end
        end else if (timed_out) begin
          nxt       = S_TRAP;
          cause_nxt = 2'd2;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_we_en   = 1'b1;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        nxt        = end_state;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IDLE;
    endcase
  end

  // wait_cnt only survives while stalled in FETCH/MEM; any other transition clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      trap_cause <= 2'd0;
      retired    <= 32'd0;
      wait_cnt   <= 16'd0;
    end else begin
      cur        <= nxt;
      trap_cause <= cause_nxt;
      wait_cnt   <= wait_inc ? wait_cnt + 16'd1 : 16'd0;
      if (instr_done) retired <= retired + 32'd1;
    end
  end

endmodule
